// File: rtl/sharpen_window_gen_if.sv
// Pixel stream bus for the sharpening window generator.
// Master drives pixels in; slave returns windows and sharpened pixels.
interface sharpen_window_gen_if #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int PIX_W = 8
);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int COL_W = $clog2(IMG_W);

    logic               IN_VALID;
    logic [PIX_W-1:0]   IN_PIX;
    logic               WIN_VALID;
    logic [9*PIX_W-1:0] WIN;
    logic [ROW_W-1:0]   OUT_ROW;
    logic [COL_W-1:0]   OUT_COL;
    logic               FRAME_DONE;
    logic               SHARP_VALID;
    logic [PIX_W-1:0]   SHARP_PIX;

    modport master (
        output IN_VALID, IN_PIX,
        input  WIN_VALID, WIN, OUT_ROW, OUT_COL,
        input  FRAME_DONE, SHARP_VALID, SHARP_PIX
    );

    modport slave (
        input  IN_VALID, IN_PIX,
        output WIN_VALID, WIN, OUT_ROW, OUT_COL,
        output FRAME_DONE, SHARP_VALID, SHARP_PIX
    );
endinterface

// File: rtl/sharpen_window_gen.sv
// Raster pixel front end: two line buffers + 3x3 window, interior windows only.
// Optional macro SHARPEN_CORE_EN adds a registered 5-point sharpening stage.
module sharpen_window_gen #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int PIX_W = 8
) (
    input logic                 CLK,
    input logic                 RESET,
    input logic                 START,
    sharpen_window_gen_if.slave bus
);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int COL_W = $clog2(IMG_W);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);

    logic [PIX_W-1:0] lb0_mem_q [IMG_W];
    logic [PIX_W-1:0] lb1_mem_q [IMG_W];
    logic [PIX_W-1:0] lb0_out, lb1_out;

    logic [ROW_W-1:0] row_q, row_d, cur_row;
    logic [COL_W-1:0] col_q, col_d, cur_col;
    logic [8:0][PIX_W-1:0] win_q, win_d;
    logic [9*PIX_W-1:0] win_out_q, win_out_d;
    logic [ROW_W-1:0] out_row_q, out_row_d;
    logic [COL_W-1:0] out_col_q, out_col_d;
    logic win_valid_q, win_valid_d;
    logic frame_done_q, frame_done_d;
    logic accept, emit;

    // Next-state: counters, window shift and emission on each accepted pixel
    always_comb begin
        accept       = bus.IN_VALID;
        cur_row      = START ? '0 : row_q;
        cur_col      = START ? '0 : col_q;
        lb0_out      = lb0_mem_q[cur_col];
        lb1_out      = lb1_mem_q[cur_col];
        row_d        = cur_row;
        col_d        = cur_col;
        win_d        = win_q;
        win_out_d    = win_out_q;
        out_row_d    = out_row_q;
        out_col_d    = out_col_q;
        win_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        emit         = 1'b0;
        if (accept) begin
            win_d = {win_q[7], win_q[6], lb0_out,
                     win_q[4], win_q[3], lb1_out,
                     win_q[1], win_q[0], bus.IN_PIX};
            emit = (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
            if (emit) begin
                win_valid_d = 1'b1;
                win_out_d   = win_d;
                out_row_d   = cur_row - ROW_W'(1);
                out_col_d   = cur_col - COL_W'(1);
            end
            frame_done_d = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
            end else begin
                col_d = cur_col + COL_W'(1);
            end
        end
    end

    // Line buffers: row-1 moves into the row-2 buffer, new pixel into row-1
    always_ff @(posedge CLK) begin
        if (accept && !RESET) begin
            lb0_mem_q[cur_col] <= lb1_out;
            lb1_mem_q[cur_col] <= bus.IN_PIX;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            row_q        <= '0;
            col_q        <= '0;
            win_q        <= '0;
            win_out_q    <= '0;
            out_row_q    <= '0;
            out_col_q    <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            row_q        <= row_d;
            col_q        <= col_d;
            win_q        <= win_d;
            win_out_q    <= win_out_d;
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.WIN_VALID  = win_valid_q;
    assign bus.WIN        = win_out_q;
    assign bus.OUT_ROW    = out_row_q;
    assign bus.OUT_COL    = out_col_q;
    assign bus.FRAME_DONE = frame_done_q;

`ifdef SHARPEN_CORE_EN
    logic               sharp_valid_q, sharp_valid_d;
    logic [PIX_W-1:0]   sharp_pix_q, sharp_pix_d;
    logic signed [11:0] c_s, n_s, s_s, e_s, w_s, sum;

    // Sharpen the emitted window: 5C - N - S - E - W, clamped to 0..255
    always_comb begin
        c_s = $signed({4'b0000, win_out_q[4*PIX_W +: PIX_W]});
        n_s = $signed({4'b0000, win_out_q[7*PIX_W +: PIX_W]});
        s_s = $signed({4'b0000, win_out_q[1*PIX_W +: PIX_W]});
        e_s = $signed({4'b0000, win_out_q[3*PIX_W +: PIX_W]});
        w_s = $signed({4'b0000, win_out_q[5*PIX_W +: PIX_W]});
        sum = (c_s <<< 2) + c_s - n_s - s_s - e_s - w_s;
        sharp_valid_d = win_valid_q && !START;
        sharp_pix_d   = sharp_pix_q;
        if (win_valid_q) begin
            if (sum < 12'sd0)
                sharp_pix_d = '0;
            else if (sum > 12'sd255)
                sharp_pix_d = 8'd255;
            else
                sharp_pix_d = sum[PIX_W-1:0];
        end
    end

    // Sharpening output register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sharp_valid_q <= 1'b0;
            sharp_pix_q   <= '0;
        end else begin
            sharp_valid_q <= sharp_valid_d;
            sharp_pix_q   <= sharp_pix_d;
        end
    end

    assign bus.SHARP_VALID = sharp_valid_q;
    assign bus.SHARP_PIX   = sharp_pix_q;
`else
    assign bus.SHARP_VALID = 1'b0;
    assign bus.SHARP_PIX   = '0;
`endif
endmodule

// File: tb/tb_sharpen_window_gen.sv
// Directed bench for sharpen_window_gen on a 4x4 image.
// Checks windows, coordinates, FRAME_DONE, START/RESET and sharpening.
module tb_sharpen_window_gen;
    logic CLK = 1'b0;
    logic RESET;
    logic START;

    sharpen_window_gen_if #(.IMG_W(4), .IMG_H(4)) bus ();

    sharpen_window_gen #(.IMG_W(4), .IMG_H(4)) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .START(START),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    localparam logic [71:0] W0 = {8'd0, 8'd1, 8'd2, 8'd4, 8'd5,
                                  8'd6, 8'd8, 8'd9, 8'd10};
    localparam logic [71:0] W1 = {8'd1, 8'd2, 8'd3, 8'd5, 8'd6,
                                  8'd7, 8'd9, 8'd10, 8'd11};
    localparam logic [71:0] W2 = {8'd4, 8'd5, 8'd6, 8'd8, 8'd9,
                                  8'd10, 8'd12, 8'd13, 8'd14};
    localparam logic [71:0] W3 = {8'd5, 8'd6, 8'd7, 8'd9, 8'd10,
                                  8'd11, 8'd13, 8'd14, 8'd15};

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int acc_cnt = 0;
    logic acc_edge = 1'b0;

    logic [71:0] ev_win [64];
    int ev_row [64];
    int ev_col [64];
    int ev_acc [64];
    int ev_cyc [64];
    logic ev_fd [64];
    int ev_n = 0;
    int sh_pix [64];
    int sh_cyc [64];
    int sh_n = 0;
    int fd_n = 0;
    int idle_bad = 0;
    int eb, sb, ab, fb, ib;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        acc_edge <= bus.IN_VALID && !RESET;
        if (bus.IN_VALID && !RESET)
            acc_cnt <= acc_cnt + 1;
    end

    always @(negedge CLK) begin
        if (bus.WIN_VALID) begin
            if (!acc_edge) idle_bad++;
            if (ev_n < 64) begin
                ev_win[ev_n] = bus.WIN;
                ev_row[ev_n] = int'(bus.OUT_ROW);
                ev_col[ev_n] = int'(bus.OUT_COL);
                ev_acc[ev_n] = acc_cnt;
                ev_cyc[ev_n] = cyc;
                ev_fd[ev_n]  = bus.FRAME_DONE;
            end
            ev_n++;
        end
        if (bus.FRAME_DONE) fd_n++;
        if (bus.SHARP_VALID) begin
            if (sh_n < 64) begin
                sh_pix[sh_n] = int'(bus.SHARP_PIX);
                sh_cyc[sh_n] = cyc;
            end
            sh_n++;
        end
    end

    task automatic check(input string tag, input logic [71:0] got,
                         input logic [71:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] p,
                        input logic s, input logic r);
        bus.IN_VALID = v;
        bus.IN_PIX   = p;
        START        = s;
        RESET        = r;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [7:0] pix(input int mode, input int r,
                                       input int c);
        case (mode)
            0: pix = 8'(r * 4 + c);
            1: pix = 8'd100;
            2: pix = (r == 1 && c == 1) ? 8'd255 : 8'd0;
            default: pix = (r == 2 && c == 2) ? 8'd0 : 8'd255;
        endcase
    endfunction

    task automatic send_frame(input int mode, input int gap,
                              input bit st);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                step(1'b1, pix(mode, r, c), st && r == 0 && c == 0, 1'b0);
                for (int g = 0; g < gap; g++)
                    step(1'b0, 8'd0, 1'b0, 1'b0);
            end
        for (int g = 0; g < 3; g++)
            step(1'b0, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic mark();
        eb = ev_n;
        sb = sh_n;
        ab = acc_cnt;
        fb = fd_n;
        ib = idle_bad;
    endtask

    task automatic check_outs_zero(input string pre);
        check({pre, "_wv"}, 72'(bus.WIN_VALID), 72'd0);
        check({pre, "_win"}, bus.WIN, 72'd0);
        check({pre, "_row"}, 72'(bus.OUT_ROW), 72'd0);
        check({pre, "_col"}, 72'(bus.OUT_COL), 72'd0);
        check({pre, "_fd"}, 72'(bus.FRAME_DONE), 72'd0);
        check({pre, "_sv"}, 72'(bus.SHARP_VALID), 72'd0);
        check({pre, "_sp"}, 72'(bus.SHARP_PIX), 72'd0);
    endtask

    task automatic check_ramp(input string pre);
        logic [71:0] ew [4];
        int er [4];
        int ec [4];
        int es [4];
        ew = '{W0, W1, W2, W3};
        er = '{1, 1, 2, 2};
        ec = '{1, 2, 1, 2};
        es = '{5, 6, 9, 10};
        check({pre, "_nwin"}, 72'(ev_n - eb), 72'd4);
        check({pre, "_nfd"}, 72'(fd_n - fb), 72'd1);
        check({pre, "_lat"}, 72'(ev_acc[eb] - ab), 72'd11);
        check({pre, "_idle"}, 72'(idle_bad - ib), 72'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_win%0d", pre, i), ev_win[eb+i], ew[i]);
            check($sformatf("%s_row%0d", pre, i),
                  72'(ev_row[eb+i]), 72'(er[i]));
            check($sformatf("%s_col%0d", pre, i),
                  72'(ev_col[eb+i]), 72'(ec[i]));
            check($sformatf("%s_fd%0d", pre, i),
                  72'(ev_fd[eb+i]), 72'(i == 3));
        end
`ifdef SHARPEN_CORE_EN
        check({pre, "_nsh"}, 72'(sh_n - sb), 72'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_sh%0d", pre, i),
                  72'(sh_pix[sb+i]), 72'(es[i]));
            check($sformatf("%s_shlat%0d", pre, i),
                  72'(sh_cyc[sb+i] - ev_cyc[eb+i]), 72'd1);
        end
`else
        check({pre, "_nsh"}, 72'(sh_n - sb), 72'd0);
`endif
    endtask

    initial begin
        bus.IN_VALID = 1'b0;
        bus.IN_PIX   = 8'd0;
        START        = 1'b0;
        RESET        = 1'b1;
        step(1'b0, 8'd0, 1'b0, 1'b1);
        step(1'b0, 8'd0, 1'b0, 1'b1);
        check_outs_zero("rst");

        mark();
        send_frame(0, 0, 1'b0);
        check_ramp("s1");

        mark();
        send_frame(1, 0, 1'b1);
        check("s2_nwin", 72'(ev_n - eb), 72'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("s2_win%0d", i), ev_win[eb+i], {9{8'd100}});
`ifdef SHARPEN_CORE_EN
            check($sformatf("s2_sh%0d", i), 72'(sh_pix[sb+i]), 72'd100);
`endif
        end

        mark();
        send_frame(2, 0, 1'b0);
        check("s3a_nwin", 72'(ev_n - eb), 72'd4);
        check("s3a_ctr", 72'(ev_win[eb][39:32]), 72'd255);
`ifdef SHARPEN_CORE_EN
        check("s3a_hi", 72'(sh_pix[sb]), 72'd255);
        check("s3a_lo", 72'(sh_pix[sb+1]), 72'd0);
`else
        check("s3a_nsh", 72'(sh_n - sb), 72'd0);
        check("s3a_sp", 72'(bus.SHARP_PIX), 72'd0);
`endif
        mark();
        send_frame(3, 0, 1'b0);
        check("s3b_ctr", 72'(ev_win[eb+3][39:32]), 72'd0);
`ifdef SHARPEN_CORE_EN
        check("s3b_hi", 72'(sh_pix[sb]), 72'd255);
        check("s3b_lo", 72'(sh_pix[sb+3]), 72'd0);
`endif

        mark();
        send_frame(0, 2, 1'b0);
        check_ramp("s4");

        mark();
        for (int i = 0; i < 6; i++)
            step(1'b1, 8'(8'hC8 + i), 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b1, 1'b0);
        ab = acc_cnt;
        send_frame(0, 0, 1'b0);
        check_ramp("s5");

        for (int i = 0; i < 5; i++)
            step(1'b1, 8'h33, 1'b0, 1'b0);
        check("s6_pre", bus.WIN, W3);
        step(1'b1, 8'h77, 1'b1, 1'b1);
        check_outs_zero("s6");
        mark();
        send_frame(0, 0, 1'b0);
        check_ramp("s6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sharpen_window_gen.md
Name: sharpen_window_gen

Overview:
- Raster-order pixel front end for the image-sharpening extension.
- Accepts one 8-bit pixel per handshake and keeps two line buffers plus a 3x3 register window.
- Emits every full interior 3x3 neighbourhood with the centre pixel coordinates.
- Downstream, the DLX datapath captures the results into 32-bit pipeline registers for write-back.

Parameters:
IMG_W, 64, image width in pixels (>=3)
IMG_H, 64, image height in pixels (>=3)
PIX_W, 8, pixel width in bits (fixed at 8 for this release)

Ports:
CLK  in  1  clock, all logic on rising edge
RESET  in  1  synchronous, active-high; clears all state
START  in  1  one-cycle frame start; clears counters and valids
IN_VALID  in  1  IN_PIX is valid this cycle; pixel accepted at rising edge
IN_PIX  in  8  input pixel, raster order (row-major, col 0 first)
WIN_VALID  out  1  WIN/OUT_ROW/OUT_COL valid, one-cycle pulse
WIN  out  72  3x3 window; WIN[8k+7:8k], k=0 bottom-right (newest), 1 bottom-mid, 2 bottom-left, 3 mid-right, 4 centre, 5 mid-left, 6 top-right, 7 top-mid, 8 top-left
OUT_ROW  out  clog2(IMG_H)  row of window centre
OUT_COL  out  clog2(IMG_W)  column of window centre
FRAME_DONE  out  1  one-cycle pulse after the last pixel of a frame
SHARP_VALID  out  1  sharpened pixel valid (see Optional Feature)
SHARP_PIX  out  8  sharpened centre pixel

Behaviour:
- Reset: RESET=1 at the edge forces all outputs to 0, row/col counters to 0 and window registers to 0. Line-buffer contents need not be cleared. RESET has priority over START and IN_VALID.
- Counters: col counts 0..IMG_W-1. At the edge, col wraps to 0 and row increments. row counts 0..IMG_H-1 and wraps to 0 after the last pixel. Counters advance only on accepted pixels.
- Acceptance: IN_VALID=1 at the edge. No backpressure; the block always accepts. Gaps in IN_VALID are allowed: window, buffers and counters hold, and WIN_VALID is 0.
- Line buffers: two buffers of depth IMG_W. On acceptance:
  - Line buffer 1 outputs the pixel from row-1, same column; line buffer 0 outputs row-2, same column.
  - The buffers shift or advance, and the window shifts one column left.
  - The new right column is {lb0_out, lb1_out, IN_PIX} (top, mid, bottom).
- Window emission: WIN_VALID=1 in the cycle after acceptance of pixel (r,c) iff r>=2 and c>=2. In that cycle WIN holds rows r-2..r, cols c-2..c, OUT_ROW=r-1, OUT_COL=c-1. Latency is 1 cycle.
- Edges: border pixels are never emitted as centres. A frame yields (IMG_W-2)*(IMG_H-2) windows.
- Columns 0 and 1 of each row shift in but do not produce windows; windows never straddle rows.
- Outputs hold their last values when WIN_VALID=0; only the valid flags are pulses.
- FRAME_DONE: 1 in the cycle after acceptance of pixel (IMG_H-1, IMG_W-1), coincident with the final WIN_VALID. 0 otherwise.
- START:
  - Synchronously clears row, col, WIN_VALID, SHARP_VALID and FRAME_DONE.
  - START with IN_VALID in the same cycle: the pixel is accepted as (0,0).
  - START mid-frame abandons the frame; no further windows from the old frame are produced.
- Reset mid-frame: same as START, plus window registers are zeroed.

Optional Feature:
Macro SHARPEN_CORE_EN.
- Defined: a registered sharpening stage computes S = 5*C - N - S' - E - W.
  - C is WIN k=4; neighbours are k=7 (N), 1 (S'), 3 (E), 5 (W).
  - Signed arithmetic, at least 12 bits wide.
  - Result clamped to 0..255.
  - SHARP_VALID pulses exactly 1 cycle after WIN_VALID (2 cycles after acceptance), and SHARP_PIX holds the result.
  - START/RESET clear SHARP_VALID.
- Undefined: SHARP_VALID and SHARP_PIX are tied to 0 and no arithmetic is synthesised. Ports remain present.

Test Plan:
1. IMG_W=4, IMG_H=4; after RESET, stream pixel value row*4+col back-to-back. Windows:
   - First WIN_VALID 1 cycle after the 11th pixel, with top row 0,1,2 / middle 4,5,6 / bottom 8,9,10 and OUT_ROW=1, OUT_COL=1.
   - Exactly 4 windows in total.
   - FRAME_DONE coincides with the 4th window (centre 10).
2. Same image, with SHARPEN_CORE_EN: first SHARP_PIX = 25-1-9-4-6 = 5, 1 cycle after WIN_VALID. A constant-100 image yields SHARP_PIX=100 for all 4 windows.
3. Clamp: centre 255 with neighbours 0 -> SHARP_PIX=255. Centre 0 with neighbours 255 -> SHARP_PIX=0.
4. Same stream with IN_VALID toggling 1,0,0,1... -> identical window contents and order; WIN_VALID never asserted in an idle cycle.
5. START asserted after the 6th pixel, then a fresh 16-pixel frame -> no window uses pre-START row data; first window after the 11th new pixel; FRAME_DONE once.
6. RESET asserted for 1 cycle coincident with IN_VALID=1 and START=1 -> pixel discarded; all outputs 0 the next cycle; the following frame behaves as in scenario 1.
